// File: rtl/mem_stage.sv
// Memory-stage controller for the 64-bit LEGv8 pipeline.
// Holds the EX/MEM register, resolves branches, runs the data-memory
// req/ack handshake with a bounded wait, and fills the MEM/WB register.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | EX/MEM holds no outstanding memory access; dm_req low
// BUSY  | EX/MEM holds a load/store waiting for dm_ack (or timeout)
module mem_stage #(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic         zero_E,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  input  logic         Branch_E,
  input  logic         RegWrite_E,
  input  logic         MemtoReg_E,
  input  logic [4:0]   rd_E,
  output logic         stall_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic [N-1:0] dm_rdata,
  input  logic         dm_ack,
  output logic         valid_W,
  output logic         RegWrite_W,
  output logic         MemtoReg_W,
  output logic [N-1:0] readData_W,
  output logic [N-1:0] aluResult_W,
  output logic [4:0]   rd_W,
  output logic         err_M
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;

  logic         valid_M;
  logic [N-1:0] aluResult_M;
  logic [N-1:0] writeData_M;
  logic         zero_M;
  logic         MemRead_M;
  logic         MemWrite_M;
  logic         Branch_M;
  logic         RegWrite_M;
  logic         MemtoReg_M;
  logic [4:0]   rd_M;

  logic busy;
  logic timeout;
  logic memop_E;
  logic load_done;

  assign busy    = (state == BUSY);
  assign memop_E = valid_E & (MemRead_E | MemWrite_E);
  // Counter only advances while stalled, so it tops out at TIMEOUT-1.
  assign timeout = busy & (wait_cnt == CW'(TIMEOUT - 1)) & ~dm_ack;
  assign stall_M = busy & ~dm_ack & ~timeout;
  // Read+write together behaves as a store, so only a pure read returns data.
  assign load_done = busy & dm_ack & MemRead_M & ~MemWrite_M;

  assign PCSrc_M  = valid_M & Branch_M & zero_M;
  assign dm_req   = busy;
  assign dm_we    = busy & MemWrite_M;
  assign dm_addr  = busy ? aluResult_M : '0;
  assign dm_wdata = busy ? writeData_M : '0;

  // EX/MEM register: loads whenever the stage is not stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_M     <= 1'b0;
      aluResult_M <= '0;
      writeData_M <= '0;
      PCBranch_M  <= '0;
      zero_M      <= 1'b0;
      MemRead_M   <= 1'b0;
      MemWrite_M  <= 1'b0;
      Branch_M    <= 1'b0;
      RegWrite_M  <= 1'b0;
      MemtoReg_M  <= 1'b0;
      rd_M        <= '0;
    end else if (!stall_M) begin
      valid_M     <= valid_E;
      aluResult_M <= aluResult_E;
      writeData_M <= writeData_E;
      PCBranch_M  <= PCBranch_E;
      zero_M      <= zero_E;
      MemRead_M   <= MemRead_E;
      MemWrite_M  <= MemWrite_E;
      Branch_M    <= Branch_E;
      RegWrite_M  <= RegWrite_E;
      MemtoReg_M  <= MemtoReg_E;
      rd_M        <= rd_E;
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state: BUSY tracks "EX/MEM holds an unfinished memop".
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    if (stall_M) begin
      state_nxt    = BUSY;
      wait_cnt_nxt = wait_cnt + 1'b1;
    end else if (memop_E) begin
      state_nxt = BUSY;
    end else begin
      state_nxt = IDLE;
    end
  end

  // MEM/WB register: real instruction on free edges, bubble while stalled.
  always_ff @(posedge clk) begin
    if (reset || stall_M) begin
      valid_W     <= 1'b0;
      RegWrite_W  <= 1'b0;
      MemtoReg_W  <= 1'b0;
      readData_W  <= '0;
      aluResult_W <= '0;
      rd_W        <= '0;
    end else begin
      valid_W     <= valid_M;
      RegWrite_W  <= RegWrite_M & ~timeout;
      MemtoReg_W  <= MemtoReg_M;
      readData_W  <= load_done ? dm_rdata : '0;
      aluResult_W <= aluResult_M;
      rd_W        <= rd_M;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_M <= 1'b0;
    end else if (timeout) begin
      err_M <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: a vector table for
// single-cycle instructions plus hand-written memory handshake sequences.
module tb_mem_stage;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_E;
  logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
  logic         zero_E, MemRead_E, MemWrite_E, Branch_E, RegWrite_E, MemtoReg_E;
  logic [4:0]   rd_E;
  logic         stall_M, PCSrc_M;
  logic [N-1:0] PCBranch_M;
  logic         dm_req, dm_we;
  logic [N-1:0] dm_addr, dm_wdata, dm_rdata;
  logic         dm_ack;
  logic         valid_W, RegWrite_W, MemtoReg_W;
  logic [N-1:0] readData_W, aluResult_W;
  logic [4:0]   rd_W;
  logic         err_M;

  int passed = 0;
  int total  = 0;

  mem_stage #(.N(N), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .aluResult_E(aluResult_E),
    .writeData_E(writeData_E), .PCBranch_E(PCBranch_E), .zero_E(zero_E),
    .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E), .Branch_E(Branch_E),
    .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .rd_E(rd_E),
    .stall_M(stall_M), .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .valid_W(valid_W),
    .RegWrite_W(RegWrite_W), .MemtoReg_W(MemtoReg_W), .readData_W(readData_W),
    .aluResult_W(aluResult_W), .rd_W(rd_W), .err_M(err_M)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [63:0] alu;
    logic [63:0] pcb;
    logic        zero;
    logic        branch;
    logic        regwrite;
    logic [4:0]  rd;
    logic        exp_pcsrc;
    logic        exp_valid_w;
    logic [63:0] exp_alu_w;
    logic [4:0]  exp_rd_w;
    logic        exp_rw_w;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_e();
    valid_E = 0; aluResult_E = '0; writeData_E = '0; PCBranch_E = '0;
    zero_E = 0; MemRead_E = 0; MemWrite_E = 0; Branch_E = 0;
    RegWrite_E = 0; MemtoReg_E = 0; rd_E = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  vec_t vecs[4];
  int   stalls;
  int   pulses;

  initial begin
    clear_e();
    dm_ack = 0;
    dm_rdata = '0;

    vecs[0] = '{1'b1, 64'h10,  64'h0,   1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 64'h10,  5'd3, 1'b1};
    vecs[1] = '{1'b1, 64'h0,   64'h100, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 64'h0,   5'd0, 1'b0};
    vecs[2] = '{1'b1, 64'h4,   64'h200, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 64'h4,   5'd0, 1'b0};
    vecs[3] = '{1'b0, 64'h55,  64'h300, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 64'h55,  5'd7, 1'b0};

    // Reset state
    do_reset();
    chk("rst_stall", stall_M, 0);
    chk("rst_pcsrc", PCSrc_M, 0);
    chk("rst_dm_req", dm_req, 0);
    chk("rst_dm_we", dm_we, 0);
    chk("rst_valid_w", valid_W, 0);
    chk("rst_err", err_M, 0);

    // Single-cycle instructions from the table
    for (int i = 0; i < 4; i++) begin
      valid_E = vecs[i].valid; aluResult_E = vecs[i].alu; PCBranch_E = vecs[i].pcb;
      zero_E = vecs[i].zero; Branch_E = vecs[i].branch; RegWrite_E = vecs[i].regwrite;
      rd_E = vecs[i].rd;
      tick();
      chk($sformatf("v%0d_pcsrc", i), PCSrc_M, vecs[i].exp_pcsrc);
      chk($sformatf("v%0d_pcbranch", i), PCBranch_M, vecs[i].pcb);
      chk($sformatf("v%0d_stall", i), stall_M, 0);
      chk($sformatf("v%0d_dm_req", i), dm_req, 0);
      clear_e();
      tick();
      chk($sformatf("v%0d_pcsrc_off", i), PCSrc_M, 0);
      chk($sformatf("v%0d_valid_w", i), valid_W, vecs[i].exp_valid_w);
      chk($sformatf("v%0d_alu_w", i), aluResult_W, vecs[i].exp_alu_w);
      chk($sformatf("v%0d_rd_w", i), rd_W, vecs[i].exp_rd_w);
      chk($sformatf("v%0d_rw_w", i), RegWrite_W, vecs[i].exp_rw_w);
    end

    // LDUR with ack three cycles after dm_req rises; ADD queued behind it
    valid_E = 1; MemRead_E = 1; MemtoReg_E = 1; RegWrite_E = 1; rd_E = 5; aluResult_E = 64'h40;
    tick();
    clear_e();
    valid_E = 1; RegWrite_E = 1; rd_E = 9; aluResult_E = 64'h77;
    stalls = 0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      dm_ack = (c == 3);
      dm_rdata = (c == 3) ? 64'hDEAD : 64'h0BAD;
      #1;
      chk($sformatf("ld_req_c%0d", c), dm_req, 1);
      chk($sformatf("ld_addr_c%0d", c), dm_addr, 64'h40);
      chk($sformatf("ld_we_c%0d", c), dm_we, 0);
      if (stall_M) stalls++;
      tick();
      if (valid_W) pulses++;
    end
    dm_ack = 0;
    clear_e();
    chk("ld_stall_cycles", stalls, 3);
    chk("ld_valid_pulses", pulses, 1);
    chk("ld_rdata_w", readData_W, 64'hDEAD);
    chk("ld_memtoreg_w", MemtoReg_W, 1);
    chk("ld_rd_w", rd_W, 5);
    chk("ld_rw_w", RegWrite_W, 1);
    tick();
    chk("add_after_ld_valid", valid_W, 1);
    chk("add_after_ld_alu", aluResult_W, 64'h77);
    chk("add_after_ld_rd", rd_W, 9);
    chk("add_after_ld_rdata", readData_W, 0);

    // STUR zero-wait, then back-to-back LDUR zero-wait
    valid_E = 1; MemWrite_E = 1; aluResult_E = 64'h8; writeData_E = 64'hAB;
    tick();
    clear_e();
    valid_E = 1; MemRead_E = 1; MemtoReg_E = 1; RegWrite_E = 1; rd_E = 2; aluResult_E = 64'h18;
    dm_ack = 1; dm_rdata = 64'h1234;
    #1;
    chk("st_req", dm_req, 1);
    chk("st_we", dm_we, 1);
    chk("st_addr", dm_addr, 64'h8);
    chk("st_wdata", dm_wdata, 64'hAB);
    chk("st_stall", stall_M, 0);
    tick();
    clear_e();
    #1;
    chk("ld2_req", dm_req, 1);
    chk("ld2_we", dm_we, 0);
    chk("ld2_addr", dm_addr, 64'h18);
    chk("ld2_stall", stall_M, 0);
    chk("st_valid_w", valid_W, 1);
    chk("st_rw_w", RegWrite_W, 0);
    chk("st_rdata_w", readData_W, 0);
    tick();
    dm_ack = 0;
    #1;
    chk("ld2_rdata_w", readData_W, 64'h1234);
    chk("ld2_rw_w", RegWrite_W, 1);
    chk("ld2_rd_w", rd_W, 2);
    chk("ld2_done_req", dm_req, 0);

    // LDUR with no ack: timeout after 15 stall cycles
    valid_E = 1; MemRead_E = 1; MemtoReg_E = 1; RegWrite_E = 1; rd_E = 4; aluResult_E = 64'h80;
    tick();
    clear_e();
    chk("to_err_before", err_M, 0);
    stalls = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!stall_M) break;
      stalls++;
      tick();
    end
    chk("to_req_last", dm_req, 1);
    tick();
    chk("to_stall_cycles", stalls, 15);
    chk("to_err", err_M, 1);
    chk("to_valid_w", valid_W, 1);
    chk("to_rw_w", RegWrite_W, 0);
    chk("to_rdata_w", readData_W, 0);
    chk("to_req_after", dm_req, 0);
    tick();
    tick();
    chk("to_err_sticky", err_M, 1);
    chk("to_stall_after", stall_M, 0);

    // Reset in the middle of a wait; later stray acks are ignored
    valid_E = 1; MemRead_E = 1; RegWrite_E = 1; rd_E = 6; aluResult_E = 64'hC0;
    tick();
    clear_e();
    tick(); tick(); tick(); tick();
    chk("mid_stall_before", stall_M, 1);
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("mid_req", dm_req, 0);
    chk("mid_stall", stall_M, 0);
    chk("mid_valid_w", valid_W, 0);
    chk("mid_err", err_M, 0);
    dm_ack = 1; dm_rdata = 64'hFFFF;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (valid_W || dm_req || stall_M) pulses++;
    end
    dm_ack = 0;
    chk("mid_idle_quiet", pulses, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
